// File: rtl/router_pkg.sv
// router_pkg: shared router sizes, index/vector types and arbiter state encoding
package router_pkg;
  localparam int N_PORTS = 16;
  localparam int IDX_W = $clog2(N_PORTS);
  typedef logic [IDX_W-1:0] port_idx_t;
  typedef logic [N_PORTS-1:0] port_vec_t;
  typedef enum logic [1:0] {ARB_IDLE = 2'd0, ARB_OWNED = 2'd1} arb_state_t;
endpackage

// File: rtl/output_port_arbiter_rr_priority_picker.sv
// rr_priority_picker: combinational round-robin winner, first request after rr_ptr
//   req     in   N_PORTS  request vector
//   rr_ptr  in   IDX_W    last winner; it becomes lowest priority
//   winner  out  IDX_W    first set bit scanning rr_ptr+1, rr_ptr+2, ... (mod N_PORTS)
//   any_req out  1        at least one request set
module rr_priority_picker
  import router_pkg::*;
(
  input  port_vec_t req,
  input  port_idx_t rr_ptr,
  output port_idx_t winner,
  output logic      any_req
);
  logic [IDX_W:0] sh;
  logic [2*N_PORTS-1:0] dbl;
  port_vec_t rot;
  port_idx_t first;
  // Rotate so rr_ptr+1 lands on bit 0, find the lowest set bit, rotate the index back.
  always_comb begin
    sh = {1'b0, rr_ptr} + (IDX_W+1)'(1);
    dbl = {req, req} >> sh;
    rot = dbl[N_PORTS-1:0];
    first = '0;
    for (int i = N_PORTS-1; i >= 0; i--)
      if (rot[i]) first = IDX_W'(i);
    winner = first + rr_ptr + IDX_W'(1);
    any_req = |req;
  end
endmodule

// File: rtl/output_port_arbiter.sv
// output_port_arbiter: round-robin owner selection and data switching for one router output
//   clk, reset_n        clock; synchronous active-low reset
//   request_in          per-input requests for this output
//   din16_in            per-input serial data
//   data_enable16_in    per-input payload-state flags
//   grant_out           one-hot registered grant, zero when idle
//   busy_out            an owner holds the output
//   owner_out           owner index, valid while busy_out
//   dout, frame_n_out   registered serial data and active-low frame
module output_port_arbiter
  import router_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  port_vec_t request_in,
  input  port_vec_t din16_in,
  input  port_vec_t data_enable16_in,
  output port_vec_t grant_out,
  output logic      busy_out,
  output port_idx_t owner_out,
  output logic      dout,
  output logic      frame_n_out
);
  localparam logic [1:0] S_IDLE = ARB_IDLE;
  localparam logic [1:0] S_OWNED = ARB_OWNED;
  logic [1:0] state;
  port_idx_t rr_ptr, winner;
  logic any_req;
  rr_priority_picker u_picker (
    .req(request_in),
    .rr_ptr(rr_ptr),
    .winner(winner),
    .any_req(any_req)
  );
  // The final branch covers idle-without-request, owner release and illegal
  // encodings alike; rr_ptr is kept so fairness survives a release.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      grant_out <= '0;
      busy_out <= 1'b0;
      owner_out <= '0;
      dout <= 1'b0;
      frame_n_out <= 1'b1;
      rr_ptr <= IDX_W'(N_PORTS-1);
    end else if (state == S_OWNED && request_in[owner_out]) begin
      dout <= din16_in[owner_out];
      frame_n_out <= ~data_enable16_in[owner_out];
    end else if (state == S_IDLE && any_req) begin
      state <= S_OWNED;
      grant_out <= port_vec_t'(1) << winner;
      busy_out <= 1'b1;
      owner_out <= winner;
      rr_ptr <= winner;
      dout <= 1'b0;
      frame_n_out <= 1'b1;
    end else begin
      state <= S_IDLE;
      grant_out <= '0;
      busy_out <= 1'b0;
      owner_out <= '0;
      dout <= 1'b0;
      frame_n_out <= 1'b1;
    end
  end
endmodule

// File: tb/tb_output_port_arbiter.sv
// tb_output_port_arbiter: directed self-checking bench for output_port_arbiter
module tb_output_port_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [15:0] request_in = '0;
  logic [15:0] din16_in = '0;
  logic [15:0] data_enable16_in = '0;
  logic [15:0] grant_out;
  logic busy_out;
  logic [3:0] owner_out;
  logic dout;
  logic frame_n_out;
  int checks = 0;
  int failures = 0;
  output_port_arbiter dut (
    .clk(clk),
    .reset_n(reset_n),
    .request_in(request_in),
    .din16_in(din16_in),
    .data_enable16_in(data_enable16_in),
    .grant_out(grant_out),
    .busy_out(busy_out),
    .owner_out(owner_out),
    .dout(dout),
    .frame_n_out(frame_n_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    request_in = '0;
    tick();
    reset_n = 1'b1;
  endtask
  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant_out), 0);
    chk({tag, "_busy"}, 32'(busy_out), 0);
    chk({tag, "_frame"}, 32'(frame_n_out), 1);
    chk({tag, "_dout"}, 32'(dout), 0);
  endtask
  task automatic chk_own(input string tag, input int idx);
    chk({tag, "_grant"}, 32'(grant_out), 32'(1) << idx);
    chk({tag, "_busy"}, 32'(busy_out), 1);
    chk({tag, "_owner"}, 32'(owner_out), 32'(idx));
  endtask
  initial begin
    int order[4] = '{2, 7, 12, 2};
    logic [3:0] pat = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      request_in = 16'($urandom);
      tick();
      chk_idle("rst");
    end
    reset_n = 1'b1;
    request_in = '0;
    tick();
    chk_idle("idle_noreq");
    request_in = 16'h0020;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_own("single5", 5);
    end
    request_in = '0;
    tick();
    chk_idle("single5_rel");
    do_reset();
    request_in = 16'h0003;
    tick();
    chk_own("pair_p0", 0);
    tick();
    chk_own("pair_p0_hold", 0);
    request_in = 16'h0002;
    tick();
    chk_idle("pair_gap");
    tick();
    chk_own("pair_p1", 1);
    do_reset();
    for (int r = 0; r < 4; r++) begin
      request_in = 16'h1084;
      tick();
      chk_own("rr_win", order[r]);
      for (int c = 0; c < 3; c++) begin
        tick();
        chk_own("rr_hold", order[r]);
      end
      request_in = 16'h1084 & ~(16'(1) << order[r]);
      tick();
      chk_idle("rr_gap");
    end
    do_reset();
    request_in = 16'h0008;
    tick();
    chk_own("data_own3", 3);
    chk("data_frame_pre", 32'(frame_n_out), 1);
    for (int i = 0; i < 4; i++) begin
      data_enable16_in = 16'h0008 | (16'($urandom) & 16'hfff7);
      din16_in = (16'($urandom) & 16'hfff7) | (16'(pat[3-i]) << 3);
      tick();
      chk("data_dout", 32'(dout), 32'(pat[3-i]));
      chk("data_frame", 32'(frame_n_out), 0);
    end
    data_enable16_in = 16'hfff7;
    din16_in = 16'hfff7;
    tick();
    chk("data_frame_post", 32'(frame_n_out), 1);
    chk("data_dout_post", 32'(dout), 0);
    data_enable16_in = 16'h0008;
    din16_in = 16'h0008;
    request_in = '0;
    tick();
    chk_idle("data_rel");
    data_enable16_in = '0;
    din16_in = '0;
    request_in = 16'h0200;
    tick();
    chk_own("mid_own9", 9);
    reset_n = 1'b0;
    tick();
    chk_idle("mid_rst");
    reset_n = 1'b1;
    request_in = 16'h0201;
    tick();
    chk_own("post_rst_p0", 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
